// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Purpose : Shared types, stall patterns and FSM encodings for pipeline_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    typedef logic [3:0] StallBus;

    localparam StallBus STALL_NONE = 4'b0000;
    localparam StallBus STALL_IF   = 4'b0001;
    localparam StallBus STALL_ID   = 4'b0011;
    localparam StallBus STALL_EX   = 4'b0111;
    localparam StallBus STALL_MEM  = 4'b1111;

    localparam logic [0:0] CTRL_RUN  = 1'b0;
    localparam logic [0:0] CTRL_DROP = 1'b1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Deepest requesting stage wins; patterns are never merged.
    function automatic StallBus stall_pattern(
        input logic mem_req,
        input logic ex_req,
        input logic id_req,
        input logic if_req
    );
        if (mem_req)     return STALL_MEM;
        else if (ex_req) return STALL_EX;
        else if (id_req) return STALL_ID;
        else if (if_req) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
// ============================================================================
// Module  : pipe_perf_cnt
// Purpose : Stall-cycle and accepted-branch counters; present only when
//           PIPE_PERF_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  StallBus     stall,
    input  logic        branch_accept,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= ZeroWord;
            r_flush_count  <= ZeroWord;
        end else begin
            if (stall != STALL_NONE)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (branch_accept)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`endif

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module  : pipeline_ctrl
// Purpose : Stall/flush sequencer with wrong-path fetch discard. Optional
//           performance counters under PIPE_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        ex_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [3:0]  stall,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        if_discard
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [31:0] r_target;

    logic        w_accept;
    StallBus     w_base;
    StallBus     w_stall;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;
    logic        w_pc_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_if_discard;

    // A frozen EX cannot redirect; it re-presents the branch once it advances.
    assign w_accept = ex_branch_taken & ~mem_stall_req & ~ex_stall_req;
    assign w_base   = stall_pattern(mem_stall_req, ex_stall_req, id_stall_req, if_stall_req);

    always_comb begin
        w_next_state  = r_state;
        w_stall       = w_base;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_pc_redirect = 1'b0;
        w_redirect_pc = ZeroWord;
        w_if_discard  = 1'b0;

        if (r_state == CTRL_RUN) begin
            if (w_accept) begin
                w_stall       = STALL_NONE;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
                w_redirect_pc = ex_branch_target;
                // With a fetch in flight the redirect waits until it returns.
                w_pc_redirect = ~if_stall_req;
                if (if_stall_req)
                    w_next_state = CTRL_DROP;
            end
        end else begin
            w_stall       = {(w_accept ? 3'b000 : w_base[3:1]), 1'b1};
            w_flush_if_id = w_accept;
            w_flush_id_ex = w_accept;
            w_redirect_pc = w_accept ? ex_branch_target : r_target;
            if (!if_stall_req) begin
                w_if_discard  = 1'b1;
                w_pc_redirect = 1'b1;
                w_flush_if_id = 1'b1;
                w_next_state  = CTRL_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= CTRL_RUN;
            r_target <= ZeroWord;
        end else begin
            r_state <= w_next_state;
            if (w_accept)
                r_target <= ex_branch_target;
        end
    end

    assign stall       = rst ? w_stall       : STALL_NONE;
    assign flush_if_id = rst & w_flush_if_id;
    assign flush_id_ex = rst & w_flush_id_ex;
    assign pc_redirect = rst & w_pc_redirect;
    assign redirect_pc = rst ? w_redirect_pc : ZeroWord;
    assign if_discard  = rst & w_if_discard;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_accept (rst & w_accept),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_ctrl
// Purpose : Self-checking bench for pipeline_ctrl (directed + random vs model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, id_req, ex_req, mem_req, taken;
    logic [31:0] target;
    logic [3:0]  stall;
    logic        flush_if_id, flush_id_ex, pc_redirect, if_discard;
    logic [31:0] redirect_pc;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
    logic [31:0] m_sc, m_fc;
`endif

    int errors = 0;
    int checks = 0;

    logic        m_pend;
    logic [31:0] m_tgt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .if_stall_req     (if_req),
        .id_stall_req     (id_req),
        .ex_stall_req     (ex_req),
        .mem_stall_req    (mem_req),
        .ex_branch_taken  (taken),
        .ex_branch_target (target),
        .stall            (stall),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .if_discard       (if_discard)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    wire [39:0] actual = {stall, flush_if_id, flush_id_ex, pc_redirect, redirect_pc, if_discard};

    // Reference: stall depth from the deepest requester, plus a pending-redirect
    // record (m_pend/m_tgt) for a branch taken while a fetch was outstanding.
    function automatic logic [39:0] model_exp();
        logic       acc;
        int         depth;
        logic [3:0] p, s;
        logic       fif, fie, rd, dis;
        logic [31:0] rpc;
        if (!rst) return 40'h0;
        acc   = taken && !mem_req && !ex_req;
        depth = mem_req ? 4 : ex_req ? 3 : id_req ? 2 : if_req ? 1 : 0;
        p     = 4'((1 << depth) - 1);
        if (!m_pend) begin
            s   = acc ? 4'b0000 : p;
            fif = acc;
            fie = acc;
            rd  = acc && !if_req;
            rpc = acc ? target : 32'h0;
            dis = 1'b0;
        end else begin
            s   = {(acc ? 3'b000 : p[3:1]), 1'b1};
            fif = acc || !if_req;
            fie = acc;
            rd  = !if_req;
            rpc = acc ? target : m_tgt;
            dis = !if_req;
        end
        return {s, fif, fie, rd, rpc, dis};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pend <= 1'b0;
            m_tgt  <= 32'h0;
`ifdef PIPE_PERF_CNT_EN
            m_sc   <= 32'h0;
            m_fc   <= 32'h0;
`endif
        end else begin
            if (!m_pend) begin
                if (taken && !mem_req && !ex_req && if_req) begin
                    m_pend <= 1'b1;
                    m_tgt  <= target;
                end
            end else begin
                if (taken && !mem_req && !ex_req) m_tgt <= target;
                if (!if_req) m_pend <= 1'b0;
            end
`ifdef PIPE_PERF_CNT_EN
            if (model_exp() >> 36 != 0) m_sc <= m_sc + 32'd1;
            if (taken && !mem_req && !ex_req) m_fc <= m_fc + 32'd1;
`endif
        end
    end

    task automatic drive(input logic r, input logic fi, input logic di, input logic e,
                         input logic m, input logic t, input logic [31:0] tg);
        rst = r; if_req = fi; id_req = di; ex_req = e; mem_req = m; taken = t; target = tg;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (actual !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", actual);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (actual !== 40'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", actual);
        end
        next_cycle();
    endtask

    task automatic test_stall_priority();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 4'b1111 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL prio_id_mem: stall=%b fl=%b%b expected 1111 00", stall, flush_if_id, flush_id_ex);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 4'b0011) begin
            errors++;
            $display("FAIL prio_id: stall=%b expected 0011", stall);
        end
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 4'b0111) begin
            errors++;
            $display("FAIL prio_ex: stall=%b expected 0111", stall);
        end
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 4'b0001) begin
            errors++;
            $display("FAIL prio_if: stall=%b expected 0001", stall);
        end
        next_cycle();
    endtask

    task automatic test_branch_frozen();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        @(negedge clk);
        checks++;
        if (pc_redirect !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || stall !== 4'b1111) begin
            errors++;
            $display("FAIL branch_frozen: redir=%b fl=%b%b stall=%b expected 0 00 1111",
                     pc_redirect, flush_if_id, flush_id_ex, stall);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        @(negedge clk);
        checks++;
        if (actual !== {4'b0000, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0}) begin
            errors++;
            $display("FAIL branch_released: got %h expected %h", actual,
                     {4'b0000, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0});
        end
        next_cycle();
    endtask

    task automatic test_load_use_branch();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || pc_redirect !== 1'b1) begin
            errors++;
            $display("FAIL load_use_branch: stall=%b fl=%b%b redir=%b expected 0000 11 1",
                     stall, flush_if_id, flush_id_ex, pc_redirect);
        end
        next_cycle();
    endtask

    task automatic test_outstanding_fetch();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 ||
            pc_redirect !== 1'b0 || if_discard !== 1'b0) begin
            errors++;
            $display("FAIL drop_entry: stall=%b fl=%b%b redir=%b disc=%b expected 0000 11 0 0",
                     stall, flush_if_id, flush_id_ex, pc_redirect, if_discard);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checks++;
            if (stall[0] !== 1'b1 || pc_redirect !== 1'b0 || if_discard !== 1'b0) begin
                errors++;
                $display("FAIL drop_wait%0d: stall=%b redir=%b disc=%b expected stall[0]=1 0 0",
                         i, stall, pc_redirect, if_discard);
            end
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (if_discard !== 1'b1 || pc_redirect !== 1'b1 || redirect_pc !== 32'h0000_0200 ||
            flush_if_id !== 1'b1) begin
            errors++;
            $display("FAIL drop_exit: disc=%b redir=%b pc=%h fl_if_id=%b expected 1 1 00000200 1",
                     if_discard, pc_redirect, redirect_pc, flush_if_id);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (actual !== 40'h0) begin
            errors++;
            $display("FAIL drop_after: got %h expected 0", actual);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_drop();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (actual !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid_drop: got %h expected 0", actual);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (actual !== 40'h0) begin
            errors++;
            $display("FAIL post_reset_no_discard: got %h expected 0", actual);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin
            errors++;
            $display("FAIL perf_reset: stall_cycles=%0d flush_count=%0d expected 0 0",
                     stall_cycles, flush_count);
        end
`endif
        next_cycle();
    endtask

    task automatic test_random();
        logic fi = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) fi = ~fi;
            drive(($urandom_range(0, 40) != 0), fi,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), $urandom);
            @(negedge clk);
            checks++;
            if (actual !== model_exp()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, actual, model_exp());
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (stall_cycles !== m_sc || flush_count !== m_fc) begin
                errors++;
                $display("FAIL random_perf%0d: got %0d/%0d expected %0d/%0d",
                         n, stall_cycles, flush_count, m_sc, m_fc);
            end
`endif
            next_cycle();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        test_reset();
        test_stall_priority();
        test_branch_frozen();
        test_load_use_branch();
        test_outstanding_fetch();
        test_reset_mid_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
